// File: rtl/z80_opcode_tracker_pkg.sv
// Shared definitions for the Z80 opcode tracker: prefix-decoder states,
// prefix byte values and index_sel codes.
package z80_opcode_tracker_pkg;

    typedef enum logic [1:0] {
        S_BASE = 2'd0,
        S_CB   = 2'd1,
        S_ED   = 2'd2,
        S_IDX  = 2'd3
    } state_e;

    localparam logic [7:0] OP_CB = 8'hCB;
    localparam logic [7:0] OP_ED = 8'hED;
    localparam logic [7:0] OP_DD = 8'hDD;
    localparam logic [7:0] OP_FD = 8'hFD;

    localparam logic [1:0] IDX_NONE = 2'd0;
    localparam logic [1:0] IDX_IX   = 2'd1;
    localparam logic [1:0] IDX_IY   = 2'd2;

    function automatic logic [1:0] idx_code(input logic [7:0] b);
        return (b == OP_FD) ? IDX_IY : IDX_IX;
    endfunction

endpackage

// File: rtl/z80_bus_sync.sv
// Brings m1_n, iorq_n and the data bus into clk, holds the last byte seen
// during M1 and flags the M1 rising edge (fetch end).
module z80_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       m1_n_i,
    input  logic       iorq_n_i,
    output logic       fetch_end_o,
    output logic [7:0] hold_data_o,
    output logic       hold_iorq_n_o
);

    logic [SYNC_STAGES-1:0]      m1_sync_q;
    logic [SYNC_STAGES-1:0]      iorq_sync_q;
    logic [SYNC_STAGES-1:0][7:0] data_sync_q;
    logic                        m1_prev_q;
    logic [7:0]                  hold_data_q;
    logic                        hold_iorq_n_q;
    logic                        m1_s;

    assign m1_s = m1_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m1_sync_q     <= '1;
            iorq_sync_q   <= '1;
            data_sync_q   <= '0;
            m1_prev_q     <= 1'b1;
            hold_data_q   <= 8'h00;
            hold_iorq_n_q <= 1'b1;
        end else begin
            m1_sync_q[0]   <= m1_n_i;
            iorq_sync_q[0] <= iorq_n_i;
            data_sync_q[0] <= data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                m1_sync_q[i]   <= m1_sync_q[i-1];
                iorq_sync_q[i] <= iorq_sync_q[i-1];
                data_sync_q[i] <= data_sync_q[i-1];
            end
            m1_prev_q <= m1_s;
            // Keep refreshing while M1 is low so the byte seen last before release wins
            if (!m1_s) begin
                hold_data_q   <= data_sync_q[SYNC_STAGES-1];
                hold_iorq_n_q <= iorq_sync_q[SYNC_STAGES-1];
            end
        end
    end

    assign fetch_end_o   = m1_s & ~m1_prev_q;
    assign hold_data_o   = hold_data_q;
    assign hold_iorq_n_o = hold_iorq_n_q;

endmodule

// File: rtl/z80_opcode_tracker.sv
// Z80 M1 opcode tracker: prefix decode FSM, instruction boundary flags,
// I/O direction, interrupt-acknowledge strobe and ED untrap detection.
//   state  | meaning
//   S_BASE | next M1 starts a new instruction
//   S_CB   | CB seen, one more opcode byte to come
//   S_ED   | ED seen, second byte checked against the trap list
//   S_IDX  | one or more DD/FD index prefixes seen
module z80_opcode_tracker
    import z80_opcode_tracker_pkg::*;
#(
    parameter int                      TRAP_COUNT   = 1,
    parameter logic [TRAP_COUNT*8-1:0] TRAP_OPCODES = 8'h45,
    parameter int                      SYNC_STAGES  = 2,
    parameter int                      CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data,
    input  logic                 m1_n,
    input  logic                 iorq_n,
    input  logic                 ignore_next_isr,
    output logic                 new_isr,
    output logic                 last_isr_untrap,
    output logic                 untrap_pulse,
    output logic                 io_direction,
    output logic [1:0]           index_sel,
    output logic                 int_ack,
    output logic [CNT_WIDTH-1:0] isr_count
);

    logic       fetch_end;
    logic [7:0] hold_data;
    logic       hold_iorq_n;

    z80_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (data),
        .m1_n_i       (m1_n),
        .iorq_n_i     (iorq_n),
        .fetch_end_o  (fetch_end),
        .hold_data_o  (hold_data),
        .hold_iorq_n_o(hold_iorq_n)
    );

    state_e               state_q,   state_d;
    logic                 new_isr_q, new_isr_d;
    logic                 untrap_q,  untrap_d;
    logic                 pulse_q,   pulse_d;
    logic                 io_dir_q,  io_dir_d;
    logic [1:0]           idx_q,     idx_d;
    logic                 int_ack_q, int_ack_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic                 complete;

    function automatic logic is_trap(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < TRAP_COUNT; i++) begin
            if (TRAP_OPCODES[i*8 +: 8] == b) hit = 1'b1;
        end
        return hit;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BASE;
            new_isr_q <= 1'b1;
            untrap_q  <= 1'b0;
            pulse_q   <= 1'b0;
            io_dir_q  <= 1'b0;
            idx_q     <= IDX_NONE;
            int_ack_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            new_isr_q <= new_isr_d;
            untrap_q  <= untrap_d;
            pulse_q   <= pulse_d;
            io_dir_q  <= io_dir_d;
            idx_q     <= idx_d;
            int_ack_q <= int_ack_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        new_isr_d = new_isr_q;
        untrap_d  = untrap_q;
        pulse_d   = 1'b0;
        io_dir_d  = io_dir_q;
        idx_d     = idx_q;
        int_ack_d = 1'b0;
        cnt_d     = cnt_q;
        complete  = 1'b0;

        if (fetch_end) begin
            if (!hold_iorq_n) begin
                int_ack_d = 1'b1;
                state_d   = S_BASE;
            end else begin
                untrap_d = 1'b0;
                // IN A,(n)/OUT (n),A live in Dx; elsewhere bit 0 separates IN/OUT (C)
                io_dir_d = (hold_data[7:4] == 4'hD) ? hold_data[3] : ~hold_data[0];
                case (state_q)
                    S_BASE: begin
                        if (hold_data == OP_CB) begin
                            state_d = S_CB;
                            idx_d   = IDX_NONE;
                        end else if (hold_data == OP_ED) begin
                            state_d = S_ED;
                            idx_d   = IDX_NONE;
                        end else if (hold_data == OP_DD || hold_data == OP_FD) begin
                            state_d = S_IDX;
                            idx_d   = idx_code(hold_data);
                        end else begin
                            complete = 1'b1;
                            idx_d    = IDX_NONE;
                        end
                    end
                    S_CB: complete = 1'b1;
                    S_ED: begin
                        complete = 1'b1;
                        if (is_trap(hold_data) && !ignore_next_isr) begin
                            untrap_d = 1'b1;
                            pulse_d  = 1'b1;
                        end
                    end
                    S_IDX: begin
                        if (hold_data == OP_ED) begin
                            state_d = S_ED;
                            idx_d   = IDX_NONE;
                        end else if (hold_data == OP_DD || hold_data == OP_FD) begin
                            idx_d = idx_code(hold_data);
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    default: state_d = S_BASE;
                endcase
                if (complete) begin
                    state_d = S_BASE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            new_isr_d = (state_d == S_BASE);
        end
    end

    assign new_isr         = new_isr_q;
    assign last_isr_untrap = untrap_q;
    assign untrap_pulse    = pulse_q;
    assign io_direction    = io_dir_q;
    assign index_sel       = idx_q;
    assign int_ack         = int_ack_q;
    assign isr_count       = cnt_q;

endmodule

// File: doc/z80_opcode_tracker.md
Name: z80_opcode_tracker

Overview:
- Clocked, parametrised successor to the M1-edge opcode decoder in the NABU CPLD.
- Samples the Z80 M1 opcode fetches in the system clock domain and runs a prefix state machine that handles the CB, ED, DD, FD, DDCB/FDCB and chained-index forms.
- Flags instruction boundaries, I/O direction, an interrupt-acknowledge cycle, and a configurable set of ED-prefixed "untrap" opcodes.
- Feeds the MegaMapper trap/untrap logic and I/O steering.

Parameters:
- TRAP_COUNT, 1: number of ED-prefixed opcodes that raise untrap.
- TRAP_OPCODES, 8'h45: TRAP_COUNT×8 packed list of second bytes after ED; entry 0 is in bits [7:0].
- SYNC_STAGES, 2: synchroniser depth applied equally to m1_n, iorq_n and data.
- CNT_WIDTH, 16: width of the completed-instruction counter.

Ports:
- clk  in  1  system clock; must be ≥4× the Z80 clock.
- rst  in  1  synchronous reset, active-high.
- data  in  8  Z80 data bus.
- m1_n  in  1  Z80 M1, active-low.
- iorq_n  in  1  Z80 IORQ, active-low; used only to detect interrupt-acknowledge.
- ignore_next_isr  in  1  suppresses untrap for the current decode; sampled at the fetch-end event.
- new_isr  out  1  level: the next M1 begins a new instruction.
- last_isr_untrap  out  1  level: the last completed instruction matched the trap list.
- untrap_pulse  out  1  one-clk strobe when last_isr_untrap is set.
- io_direction  out  1  0 = OUT, 1 = IN; meaningful only for I/O instructions.
- index_sel  out  2  prefix of the current/last instruction: 0 none, 1 DD (IX), 2 FD (IY).
- int_ack  out  1  one-clk strobe on each interrupt-acknowledge M1.
- isr_count  out  CNT_WIDTH  completed-instruction count; wraps.

Behaviour:
- Sampling
  - m1_n, iorq_n and data each pass through SYNC_STAGES flops.
  - While the synchronised m1 is low, capture the byte and iorq into hold registers every clk.
  - Fetch-end event: the synchronised m1_n transitions 0→1. Decode uses the hold registers.
- Interrupt acknowledge
  - If held iorq was low at fetch-end: int_ack = 1 for one clk.
  - No decode, no counter change; state forced to S_BASE, new_isr = 1.
- States: S_BASE, S_CB, S_ED, S_IDX. All transitions occur on fetch-end events only.
- S_BASE
  - CB → S_CB.
  - ED → S_ED.
  - DD or FD → S_IDX; index_sel = 1 or 2.
  - Any other byte → complete; index_sel = 0.
- S_CB: any byte → complete.
- S_ED
  - Any byte → complete.
  - If the byte equals any TRAP_OPCODES entry and ignore_next_isr = 0: last_isr_untrap = 1 and untrap_pulse = 1.
- S_IDX
  - CB → complete. The displacement and opcode that follow are non-M1 reads.
  - ED → S_ED; index_sel = 0.
  - DD or FD → stay in S_IDX; index_sel updated to the latest prefix.
  - Any other byte → complete.
- complete: return to S_BASE and increment isr_count by 1, wrapping modulo 2^CNT_WIDTH.
- new_isr = (state == S_BASE), registered, valid from the clk after fetch-end.
- last_isr_untrap
  - Cleared at every non-int-ack fetch-end unless that fetch-end sets it.
  - Otherwise holds.
- io_direction, updated at every non-int-ack fetch-end:
  - byte[7:4] == 4'hD → byte[3].
  - Otherwise → ~byte[0], which covers ED 40–7F IN/OUT (C).
- Simultaneous events: if rst and fetch-end occur together, rst wins.
- Reset values:
  - state S_BASE, new_isr 1, last_isr_untrap 0, untrap_pulse 0, io_direction 0, index_sel 0, int_ack 0, isr_count 0.
  - Synchroniser and hold registers set to m1_n = 1, iorq_n = 1, data = 0, so no fetch-end fires on reset exit.
- Reset mid-prefix discards the prefix; the next M1 decodes from S_BASE.
- Latency: outputs update 1 clk after fetch-end is detected, i.e. SYNC_STAGES+1 clks after the m1_n rising edge.

Decomposition:
- Shared package:
  - State encoding for S_BASE, S_CB, S_ED, S_IDX.
  - Prefix constants 8'hCB, 8'hED, 8'hDD, 8'hFD.
  - index_sel codes.
- Sub-module z80_bus_sync: parametrised synchroniser plus fetch-end edge detect and hold registers. The decode FSM stays in the top module.

Test Plan:
- Reset, then M1 fetches of 00, 3E (LD A,n), 00 → 3 completions; isr_count = 3; new_isr = 1 after each; index_sel = 0.
- Fetch ED then 45 with ignore_next_isr = 0 → new_isr = 0 after ED; after 45, last_isr_untrap = 1 and untrap_pulse is high for exactly 1 clk. Next fetch 00 → last_isr_untrap = 0.
- Repeat ED 45 with ignore_next_isr = 1 → last_isr_untrap stays 0; isr_count increments by 1.
- Fetches DD, FD, CB → index_sel = 1 then 2; completes at CB; isr_count += 1; next fetch 00 decodes as a new instruction.
- Fetch DB (IN A,(n)) → io_direction = 1. Fetch ED 79 (OUT (C),A) → io_direction = 0. Fetch D3 → io_direction = 0.
- Fetch DD, then an M1 with iorq_n low and data FF → int_ack = 1 for 1 clk; isr_count unchanged; new_isr = 1. Separately: assert rst between ED and 45 → the 45 decodes as a plain completion with no untrap. With CNT_WIDTH = 4, 16 completions wrap isr_count to 0.
